// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority over queued long-latency results,
// with a starvation bound. Trace outputs are populated only when RF_ARB_TRACE_EN is defined.
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    input  logic [31:0] ws_rf_wdata,
    input  logic [31:0] ws_pc,
    output logic        wb_hold,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic [31:0] pend_mask,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [AW-1:0]    widx, ridx;
    logic             fifo_empty, fifo_full;

    logic [CW-1:0]    starve_cnt_q, starve_cnt_d;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic             wb_req, push, enq, pop;
    logic             grant_wb, grant_lu, hold;
    logic [31:0]      pend_bits;

    assign widx       = wptr_q[AW-1:0];
    assign ridx       = rptr_q[AW-1:0];
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (widx == ridx);

    // A push to r0 completes the handshake but is dropped rather than queued.
    assign wb_req = ws_rf_we && (ws_rf_waddr != 5'd0);
    assign push   = lu_valid && !fifo_full;
    assign enq    = push && (lu_waddr != 5'd0);
    assign pop    = grant_lu;

    always_comb begin
        grant_wb = 1'b0;
        grant_lu = 1'b0;
        hold     = 1'b0;
        if (fifo_empty) begin
            grant_wb = wb_req;
        end else if (!wb_req) begin
            grant_lu = 1'b1;
        end else if (starve_cnt_q != CW'(STARVE_MAX)) begin
            grant_wb = 1'b1;
        end else begin
            grant_lu = 1'b1;
            hold     = 1'b1;
        end
    end

    always_comb begin
        if (fifo_empty || grant_lu) begin
            starve_cnt_d = '0;
        end else if (grant_wb) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_comb begin
        fifo_vld_d = fifo_vld_q;
        if (pop) fifo_vld_d[ridx] = 1'b0;
        if (enq) fifo_vld_d[widx] = 1'b1;
    end

    always_comb begin
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_wb) begin
            rf_waddr_d = ws_rf_waddr;
            rf_wdata_d = ws_rf_wdata;
        end else if (grant_lu) begin
            rf_waddr_d = fifo_addr_q[ridx];
            rf_wdata_d = fifo_data_q[ridx];
        end
    end

    // Pending mask is built from live entries only, so a bit drops the cycle after its pop.
    always_comb begin
        pend_bits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[i]) pend_bits[fifo_addr_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_vld_q   <= '0;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            fifo_vld_q   <= fifo_vld_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= grant_wb || grant_lu;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[widx] <= lu_waddr;
            fifo_data_q[widx] <= lu_wdata;
        end
    end

    assign wb_hold   = hold;
    assign lu_ready  = !fifo_full;
    assign pend_mask = pend_bits;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

`ifdef RF_ARB_TRACE_EN
    logic [31:0] fifo_pc_q [DEPTH];
    logic [31:0] trace_pc_q, trace_pc_d;

    always_comb begin
        trace_pc_d = trace_pc_q;
        if (grant_wb) begin
            trace_pc_d = ws_pc;
        end else if (grant_lu) begin
            trace_pc_d = fifo_pc_q[ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_pc_q <= '0;
        end else begin
            trace_pc_q <= trace_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_pc_q[widx] <= lu_pc;
    end

    assign debug_wb_pc       = trace_pc_q;
    assign debug_wb_rf_wen   = {4{rf_we_q}};
    assign debug_wb_rf_wnum  = rf_waddr_q;
    assign debug_wb_rf_wdata = rf_wdata_q;
`else
    logic unused_pc;
    assign unused_pc = ^{ws_pc, lu_pc};

    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: a queue-based reference model predicts each
// port write; a monitor pops predictions whenever the DUT writes.
module tb_rf_wport_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_rf_we = 1'b0;
    logic [4:0]  ws_rf_waddr = '0;
    logic [31:0] ws_rf_wdata = '0;
    logic [31:0] ws_pc = '0;
    logic        wb_hold;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_waddr = '0;
    logic [31:0] lu_wdata = '0;
    logic [31:0] lu_pc = '0;
    logic [31:0] pend_mask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata), .ws_pc(ws_pc),
        .wb_hold(wb_hold),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_pc(lu_pc),
        .pend_mask(pend_mask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    wr_t lu_m [$];
    wr_t exp_q [$];
    int  cnt_m = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check the combinational outputs and advance the model.
    task automatic cycle(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] wpc, input bit lv, input logic [4:0] la,
                         input logic [31:0] ld, input logic [31:0] lpc, output bit acc);
        bit full, req, ne, g_wb, g_lu, hold;
        logic [31:0] pm;
        @(negedge clk);
        reset = rst; ws_rf_we = we; ws_rf_waddr = wa; ws_rf_wdata = wd; ws_pc = wpc;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld; lu_pc = lpc;
        #1;
        acc = 1'b0;
        if (rst) begin
            lu_m.delete();
            cnt_m = 0;
        end else begin
            full = (lu_m.size() == DEPTH);
            ne   = (lu_m.size() != 0);
            req  = we && (wa != 5'd0);
            g_wb = 1'b0; g_lu = 1'b0; hold = 1'b0;
            if (!ne) g_wb = req;
            else if (!req) g_lu = 1'b1;
            else if (cnt_m < STARVE_MAX) g_wb = 1'b1;
            else begin g_lu = 1'b1; hold = 1'b1; end
            pm = '0;
            foreach (lu_m[i]) pm[lu_m[i].a] = 1'b1;
            chk("lu_ready", 64'(lu_ready), 64'(!full));
            chk("wb_hold", 64'(wb_hold), 64'(hold));
            chk("pend_mask", 64'(pend_mask), 64'(pm));
            if (g_wb) exp_q.push_back(wr_t'{a: wa, d: wd, pc: wpc});
            if (g_lu) exp_q.push_back(lu_m[0]);
            cnt_m = (!ne || g_lu) ? 0 : cnt_m + 1;
            if (g_lu) lu_m.delete(0);
            acc = lv && !full;
            if (acc && la != 5'd0) lu_m.push_back(wr_t'{a: la, d: ld, pc: lpc});
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, acc);
    endtask

    task automatic lu_push_hold(input logic [4:0] la, input logic [31:0] ld, input bit wb);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++)
            cycle(0, wb, 5'(k + 10), 32'h4000 + k, 32'h400 + k, 1, la, ld, 32'h500 + 32'(la), acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL lu_accept_timeout: got not accepted after 20 cycles, required accepted");
        end
    endtask

    always @(posedge clk) begin
        bit r;
        wr_t e;
        r = reset;
        #1;
        if (r) begin
            chk("rst_rf_we", 64'(rf_we), 64'd0);
            chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
            chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
            last = '0;
        end else if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_waddr), 64'(e.a));
                chk("wr_data", 64'(rf_wdata), 64'(e.d));
                last = e;
            end
        end else begin
            chk("idle_we", 64'(rf_we), 64'd0);
            chk("hold_waddr", 64'(rf_waddr), 64'(last.a));
            chk("hold_wdata", 64'(rf_wdata), 64'(last.d));
        end
`ifdef RF_ARB_TRACE_EN
        chk("trace_pc", 64'(debug_wb_pc), 64'(last.pc));
        chk("trace_wnum", 64'(debug_wb_rf_wnum), 64'(last.a));
        chk("trace_wdata", 64'(debug_wb_rf_wdata), 64'(last.d));
        chk("trace_wen", 64'(debug_wb_rf_wen), r ? 64'd0 : 64'({4{rf_we}}));
`else
        chk("trace_off_pc", 64'(debug_wb_pc), 64'd0);
        chk("trace_off_misc", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}), 64'd0);
`endif
    end

    initial begin
        bit acc;
        cycle(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, acc);
        cycle(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, acc);
        idle(2);

        // WB only
        cycle(0, 1, 5'd5, 32'h0000_1234, 32'h1000, 0, 5'd0, 32'd0, 32'd0, acc);
        idle(2);

        // LU only
        cycle(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd7, 32'hDEAD_BEEF, 32'h2000, acc);
        idle(3);

        // Starvation: one queued LU entry, WB every cycle
        cycle(0, 1, 5'd1, 32'h11, 32'h3000, 1, 5'd9, 32'h99, 32'h3100, acc);
        for (int k = 0; k < 7; k++)
            cycle(0, 1, 5'(k + 2), 32'h20 + k, 32'h3004 + 4 * k, 0, 5'd0, 32'd0, 32'd0, acc);
        idle(3);

        // Full FIFO with WB competing
        lu_push_hold(5'd12, 32'hA0A0_0001, 1);
        lu_push_hold(5'd13, 32'hA0A0_0002, 1);
        lu_push_hold(5'd14, 32'hA0A0_0003, 1);
        idle(8);

        // r0 on both sources
        cycle(0, 1, 5'd0, 32'h0000_0BAD, 32'h6000, 1, 5'd0, 32'h0000_BAD0, 32'h6100, acc);
        idle(3);

        // Reset with two queued entries and a partly advanced starvation count
        cycle(0, 1, 5'd3, 32'h301, 32'h7000, 1, 5'd20, 32'h2001, 32'h7100, acc);
        cycle(0, 1, 5'd4, 32'h302, 32'h7004, 1, 5'd21, 32'h2002, 32'h7104, acc);
        cycle(0, 1, 5'd5, 32'h303, 32'h7008, 0, 5'd0, 32'd0, 32'd0, acc);
        cycle(0, 1, 5'd6, 32'h304, 32'h700C, 0, 5'd0, 32'd0, 32'd0, acc);
        cycle(1, 1, 5'd7, 32'h305, 32'h7010, 0, 5'd0, 32'd0, 32'd0, acc);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 249) == 0,
                  $urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)), $urandom, $urandom,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom, $urandom, acc);
        end

        idle(12);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
